// File: rtl/ysyx_23060061_bus_pkg.sv
// Shared types and constants for the core's memory-port arbiters.
package ysyx_23060061_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIfuRd,
    StLsuRd,
    StLsuWr
  } bus_state_e;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;
  localparam logic RESP_OKAY = 1'b0;

endpackage

// File: rtl/ysyx_23060061_rr_pick.sv
// Two-way round-robin selector: on contention, the master that was not granted last wins.
module ysyx_23060061_rr_pick
  import ysyx_23060061_bus_pkg::*;
(
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_lsu
);

  always_comb begin
    grant_valid = req_ifu | req_lsu;
    grant_lsu   = req_lsu & (~req_ifu | (last_grant == GRANT_IFU));
  end

endmodule

// File: rtl/ysyx_23060061_bus_arbiter.sv
// Shares one AXI4-Lite-style slave port between the IFU (read) and the LSU (read/write).
// One transaction in flight; the grant is held from address handshake to response handshake.
module ysyx_23060061_bus_arbiter
  import ysyx_23060061_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read channel
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read channel
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write channels
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic                lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Slave port
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  bus_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       lsu_req, grant_valid, grant_lsu;

  assign lsu_req = lsu_arvalid | lsu_awvalid;

  ysyx_23060061_rr_pick u_rr_pick (
    .req_ifu     (ifu_arvalid),
    .req_lsu     (lsu_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_lsu   (grant_lsu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GRANT_LSU;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;

    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = 1'b0;
    lsu_bvalid  = 1'b0;
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          last_grant_d = grant_lsu;
          if (!grant_lsu) begin
            state_d = StIfuRd;
          end else if (lsu_arvalid) begin
            state_d = StLsuRd;
          end else begin
            state_d = StLsuWr;
          end
        end
      end
      StIfuRd: begin
        m_araddr    = ifu_araddr;
        m_arvalid   = ifu_arvalid;
        ifu_arready = m_arready;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
        if (m_rvalid && ifu_rready) state_d = StIdle;
      end
      StLsuRd: begin
        m_araddr    = lsu_araddr;
        m_arvalid   = lsu_arvalid;
        lsu_arready = m_arready;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
        if (m_rvalid && lsu_rready) state_d = StIdle;
      end
      StLsuWr: begin
        // A channel that already handshook is masked so the slave never sees a second beat.
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid & ~aw_done_q;
        lsu_awready = m_awready & ~aw_done_q;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid & ~w_done_q;
        lsu_wready  = m_wready & ~w_done_q;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid;
        m_bready    = lsu_bready;
        if (lsu_awvalid && !aw_done_q && m_awready) aw_done_d = 1'b1;
        if (lsu_wvalid && !w_done_q && m_wready) w_done_d = 1'b1;
        if (m_bvalid && lsu_bready) begin
          state_d   = StIdle;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
    endcase
  end

  // Protocol checks: responses only while a matching grant is held; valids held until accepted.
  a_r_in_read: assert property (@(posedge clk) disable iff (rst)
    m_rvalid |-> (state_q == StIfuRd || state_q == StLsuRd));
  a_b_in_write: assert property (@(posedge clk) disable iff (rst)
    m_bvalid |-> (state_q == StLsuWr));
  a_ifu_ar_hold: assert property (@(posedge clk) disable iff (rst)
    $past((state_q == StIdle && grant_valid && !grant_lsu) ||
          (state_q == StIfuRd && ifu_arvalid && !m_arready)) |-> ifu_arvalid);
  a_lsu_ar_hold: assert property (@(posedge clk) disable iff (rst)
    $past((state_q == StIdle && grant_valid && grant_lsu && lsu_arvalid) ||
          (state_q == StLsuRd && lsu_arvalid && !m_arready)) |-> lsu_arvalid);
  a_lsu_aw_hold: assert property (@(posedge clk) disable iff (rst)
    $past(state_q == StLsuWr && lsu_awvalid && !aw_done_q && !m_awready) |-> lsu_awvalid);
  a_lsu_w_hold: assert property (@(posedge clk) disable iff (rst)
    $past(state_q == StLsuWr && lsu_wvalid && !w_done_q && !m_wready) |-> lsu_wvalid);

endmodule

// File: tb/tb_ysyx_23060061_bus_arbiter.sv
// Bench for the IFU/LSU bus arbiter: reactive slave model plus an in-order response scoreboard.
module tb_ysyx_23060061_bus_arbiter;
  import ysyx_23060061_bus_pkg::*;

  localparam int Tmo = 40;

  logic        clk, rst;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
  logic        ifu_arvalid, ifu_arready, ifu_rresp, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rresp, lsu_rvalid, lsu_rready;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
  logic [3:0]  lsu_wstrb, m_wstrb;
  logic        lsu_bresp, lsu_bvalid, lsu_bready;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rresp, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready;

  ysyx_23060061_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave memory contents: the boot word at the reset vector, a pattern elsewhere.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5a5a_0000);
  endfunction

  function automatic logic [11:0] ctl_outs();
    return {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, ifu_arready, ifu_rvalid,
            lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid};
  endfunction

  function automatic logic data_outs();
    return |{m_araddr, m_awaddr, m_wdata, m_wstrb, ifu_rdata, lsu_rdata,
             ifu_rresp, lsu_rresp, lsu_bresp};
  endfunction

  // Handshakes seen at the rising edge, consumed by the negedge processes.
  logic        ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic        ifu_ar_hs, lsu_ar_hs, lsu_aw_hs, lsu_w_hs, ifu_r_hs, lsu_r_hs, lsu_b_hs;
  logic [31:0] ar_cap, aw_cap, w_cap, ifu_r_cap, lsu_r_cap;
  logic [3:0]  strb_cap;
  logic        ifu_rresp_cap, lsu_rresp_cap, lsu_b_cap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {ar_hs, aw_hs, w_hs, r_hs, b_hs} <= '0;
      {ifu_ar_hs, lsu_ar_hs, lsu_aw_hs, lsu_w_hs, ifu_r_hs, lsu_r_hs, lsu_b_hs} <= '0;
    end else begin
      ar_hs     <= m_arvalid & m_arready;
      aw_hs     <= m_awvalid & m_awready;
      w_hs      <= m_wvalid & m_wready;
      r_hs      <= m_rvalid & m_rready;
      b_hs      <= m_bvalid & m_bready;
      ifu_ar_hs <= ifu_arvalid & ifu_arready;
      lsu_ar_hs <= lsu_arvalid & lsu_arready;
      lsu_aw_hs <= lsu_awvalid & lsu_awready;
      lsu_w_hs  <= lsu_wvalid & lsu_wready;
      ifu_r_hs  <= ifu_rvalid & ifu_rready;
      lsu_r_hs  <= lsu_rvalid & lsu_rready;
      lsu_b_hs  <= lsu_bvalid & lsu_bready;
      ar_cap    <= m_araddr;
      aw_cap    <= m_awaddr;
      w_cap     <= m_wdata;
      strb_cap  <= m_wstrb;
      ifu_r_cap <= ifu_rdata;
      lsu_r_cap <= lsu_rdata;
      ifu_rresp_cap <= ifu_rresp;
      lsu_rresp_cap <= lsu_rresp;
      lsu_b_cap <= lsu_bresp;
    end
  end

  // Slave model: read data two cycles after ar, b once both aw and w have arrived.
  int unsigned ar_cnt, aw_cnt, w_cnt, awv_cycles, rd_cnt;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        aw_got, w_got;

  initial begin
    {m_arready, m_rvalid, m_rresp, m_awready, m_wready, m_bvalid, m_bresp} = '0;
    m_rdata = '0;
    {ar_cnt, aw_cnt, w_cnt, awv_cycles, rd_cnt} = '0;
    {aw_got, w_got} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {m_arready, m_rvalid, m_rresp, m_awready, m_wready, m_bvalid, m_bresp} = '0;
        m_rdata = '0;
        rd_cnt  = 0;
        {aw_got, w_got} = '0;
      end else begin
        if (m_awvalid) awv_cycles++;
        if (r_hs) m_rvalid = 1'b0;
        if (rd_cnt != 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = mem_rd(rd_addr);
            m_rresp  = RESP_OKAY;
          end
        end
        if (ar_hs) begin
          m_arready = 1'b0;
          rd_addr   = ar_cap;
          rd_cnt    = 2;
          ar_cnt++;
        end else if (m_arvalid && !m_arready && rd_cnt == 0 && !m_rvalid) begin
          m_arready = 1'b1;
        end
        if (b_hs) m_bvalid = 1'b0;
        if (aw_hs) begin
          m_awready = 1'b0;
          aw_got    = 1'b1;
          wr_addr   = aw_cap;
          aw_cnt++;
        end else if (m_awvalid && !m_awready) begin
          m_awready = 1'b1;
        end
        if (w_hs) begin
          m_wready = 1'b0;
          w_got    = 1'b1;
          wr_data  = w_cap;
          wr_strb  = strb_cap;
          w_cnt++;
        end else if (m_wvalid && !m_wready) begin
          m_wready = 1'b1;
        end
        if (aw_got && w_got && !m_bvalid) begin
          m_bvalid = 1'b1;
          m_bresp  = RESP_OKAY;
          {aw_got, w_got} = '0;
        end
      end
    end
  end

  // Scoreboard entries: {kind, resp, data}; kind 0 = IFU r, 1 = LSU r, 2 = LSU b.
  logic [34:0] exp_q[$];

  task automatic sb_pop(input string tag, input logic [34:0] got);
    if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 64'(got), 64'h0);
    else check_eq(tag, 64'(got), 64'(exp_q.pop_front()));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (ifu_r_hs) sb_pop("ifu_r", {2'd0, ifu_rresp_cap, ifu_r_cap});
      if (lsu_r_hs) sb_pop("lsu_r", {2'd1, lsu_rresp_cap, lsu_r_cap});
      if (lsu_b_hs) sb_pop("lsu_b", {2'd2, lsu_b_cap, 32'h0});
    end
  end

  task automatic push_rd(input logic [1:0] kind, input logic [31:0] a);
    exp_q.push_back({kind, RESP_OKAY, mem_rd(a)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid} = '0;
    {ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata} = '0;
    lsu_wstrb  = '0;
    ifu_rready = 1'b1;
    lsu_rready = 1'b1;
    lsu_bready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Master tasks are entered on a falling edge.
  task automatic ifu_read(input logic [31:0] a);
    int n;
    ifu_araddr  = a;
    ifu_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifu_ar_hs && n < Tmo);
    check_eq("ifu_ar_hs", 64'(ifu_ar_hs), 64'h1);
    ifu_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifu_r_hs && n < Tmo);
    check_eq("ifu_r_hs", 64'(ifu_r_hs), 64'h1);
  endtask

  task automatic lsu_read(input logic [31:0] a);
    int n;
    lsu_araddr  = a;
    lsu_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_ar_hs && n < Tmo);
    check_eq("lsu_ar_hs", 64'(lsu_ar_hs), 64'h1);
    lsu_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_r_hs && n < Tmo);
    check_eq("lsu_r_hs", 64'(lsu_r_hs), 64'h1);
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_delay);
    int n;
    lsu_awaddr  = a;
    lsu_wdata   = d;
    lsu_wstrb   = s;
    lsu_awvalid = 1'b1;
    fork
      begin
        int k = 0;
        do begin @(negedge clk); k++; end while (!lsu_aw_hs && k < Tmo);
        check_eq("lsu_aw_hs", 64'(lsu_aw_hs), 64'h1);
        check_eq("m_awvalid_after_hs", 64'(m_awvalid), 64'h0);
        lsu_awvalid = 1'b0;
      end
      begin
        int k = 0;
        repeat (w_delay) @(negedge clk);
        lsu_wvalid = 1'b1;
        do begin @(negedge clk); k++; end while (!lsu_w_hs && k < Tmo);
        check_eq("lsu_w_hs", 64'(lsu_w_hs), 64'h1);
        lsu_wvalid = 1'b0;
      end
    join
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_b_hs && n < Tmo);
    check_eq("lsu_b_hs", 64'(lsu_b_hs), 64'h1);
  endtask

  initial begin
    int unsigned aw_base, w_base, awv_base;
    do_reset();
    check_eq("reset_ctl_outs", 64'(ctl_outs()), 64'h0);
    check_eq("reset_data_outs", 64'(data_outs()), 64'h0);

    // IFU alone: forwarded one cycle after the request, IDLE again after the response.
    @(negedge clk);
    push_rd(2'd0, 32'h8000_0000);
    fork
      ifu_read(32'h8000_0000);
      begin
        @(negedge clk);
        check_eq("ifu_fwd_arvalid", 64'(m_arvalid), 64'h1);
        check_eq("ifu_fwd_araddr", 64'(m_araddr), 64'h8000_0000);
      end
    join
    check_eq("idle_after_ifu", 64'(m_rready), 64'h0);

    // Simultaneous requests right after reset: IFU first, then LSU after one IDLE cycle.
    do_reset();
    @(negedge clk);
    push_rd(2'd0, 32'h8000_0004);
    push_rd(2'd1, 32'h8000_1000);
    fork
      ifu_read(32'h8000_0004);
      lsu_read(32'h8000_1000);
      begin
        int k = 0;
        do begin @(negedge clk); k++; end while (!ifu_r_hs && k < Tmo);
        check_eq("idle_gap_arvalid", 64'(m_arvalid), 64'h0);
        @(negedge clk);
        check_eq("lsu_grant_arvalid", 64'(m_arvalid), 64'h1);
        check_eq("lsu_grant_araddr", 64'(m_araddr), 64'h8000_1000);
      end
    join

    // Repeated contention alternates IFU, LSU.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_rd(2'd0, 32'h8000_0100 + 32'(i * 4));
      push_rd(2'd1, 32'h8000_2000 + 32'(i * 4));
      fork
        ifu_read(32'h8000_0100 + 32'(i * 4));
        lsu_read(32'h8000_2000 + 32'(i * 4));
      join
    end

    // LSU write, w arriving two cycles after aw.
    @(negedge clk);
    aw_base = aw_cnt;
    w_base  = w_cnt;
    exp_q.push_back({2'd2, RESP_OKAY, 32'h0});
    lsu_write(32'h8000_3000, 32'hdead_beef, 4'hf, 2);
    check_eq("wr_aw_beats", 64'(aw_cnt - aw_base), 64'h1);
    check_eq("wr_w_beats", 64'(w_cnt - w_base), 64'h1);
    check_eq("wr_addr", 64'(wr_addr), 64'h8000_3000);
    check_eq("wr_data", 64'(wr_data), 64'hdead_beef);
    check_eq("wr_strb", 64'(wr_strb), 64'hf);

    // LSU read and write together: the read finishes before any aw is forwarded.
    @(negedge clk);
    awv_base = awv_cycles;
    push_rd(2'd1, 32'h8000_4000);
    exp_q.push_back({2'd2, RESP_OKAY, 32'h0});
    fork
      begin
        lsu_read(32'h8000_4000);
        check_eq("no_aw_during_read", 64'(awv_cycles - awv_base), 64'h0);
      end
      lsu_write(32'h8000_4004, 32'h1234_5678, 4'h3, 0);
    join
    check_eq("rw_wr_data", 64'(wr_data), 64'h1234_5678);

    // Reset in the middle of a write, after its aw handshake.
    do_reset();
    @(negedge clk);
    lsu_awaddr  = 32'h8000_5000;
    lsu_awvalid = 1'b1;
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!lsu_aw_hs && k < Tmo);
      check_eq("mid_wr_aw_hs", 64'(lsu_aw_hs), 64'h1);
    end
    lsu_awvalid = 1'b0;
    #2;
    check_eq("mid_wr_bready", 64'(m_bready), 64'h1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_ctl_outs", 64'(ctl_outs()), 64'h0);
    check_eq("async_rst_data_outs", 64'(data_outs()), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_rd(2'd0, 32'h8000_0000);
    ifu_read(32'h8000_0000);
    @(negedge clk);
    aw_base = aw_cnt;
    exp_q.push_back({2'd2, RESP_OKAY, 32'h0});
    lsu_write(32'h8000_5008, 32'h0bad_f00d, 4'h5, 1);
    check_eq("post_rst_aw_beats", 64'(aw_cnt - aw_base), 64'h1);
    check_eq("post_rst_wr_data", 64'(wr_data), 64'h0bad_f00d);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
